// File: rtl/mul_seg_drv.sv
// mul_seg_drv: transmit-side a/b symbol driver for the three-state (s0/s1/s2)
// control FSM, with a shadow model of the receiver state and its outputs.
// Optional build macro MUL_SEG_DRV_ABORT_EN adds an 'abort' input that cuts
// an in-progress H_WAIT short and jumps straight to H_EXIT.
module mul_seg_drv #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_type,
  input  logic [LEN_W-1:0] cmd_len,
`ifdef MUL_SEG_DRV_ABORT_EN
  input  logic             abort,
`endif
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic [1:0]       shadow_state,
  output logic             exp_y0,
  output logic             exp_y1
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PULSE   = 3'd1,
    S_RECOVER = 3'd2,
    S_H_ENTER = 3'd3,
    S_H_WAIT  = 3'd4,
    S_H_EXIT  = 3'd5
  } drv_state_e;

  localparam logic [1:0] SH_S0 = 2'd0;
  localparam logic [1:0] SH_S1 = 2'd1;
  localparam logic [1:0] SH_S2 = 2'd2;

  drv_state_e       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       shadow_q, shadow_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             y0_q, y0_d;
  logic             y1_q, y1_d;
  logic             abort_hit;

`ifdef MUL_SEG_DRV_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // State, counter, decoded outputs and shadow model registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= SH_S0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      y0_q     <= 1'b0;
      y1_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
    end
  end

  // Next-state logic; the counter holds the captured hold length
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = cmd_type ? S_H_ENTER : S_PULSE;
          cnt_d   = cmd_len;
        end
      end
      S_PULSE:   state_d = S_RECOVER;
      S_RECOVER: state_d = S_IDLE;
      S_H_ENTER: state_d = (cnt_q != '0) ? S_H_WAIT : S_H_EXIT;
      S_H_WAIT: begin
        cnt_d = cnt_q - LEN_W'(1);
        if ((cnt_q == LEN_W'(1)) || abort_hit) begin
          state_d = S_H_EXIT;
        end
      end
      S_H_EXIT:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Moore output decode of the upcoming driver state
  always_comb begin
    a_d     = 1'b0;
    b_d     = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    ready_d = 1'b0;
    unique case (state_d)
      S_IDLE: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      S_PULSE: begin
        a_d = 1'b1;
        b_d = 1'b1;
      end
      S_RECOVER: done_d = 1'b1;
      S_H_ENTER: a_d = 1'b1;
      S_H_WAIT:  ;
      S_H_EXIT: begin
        a_d    = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // Receiver shadow: advances on the symbol currently on the wire
  always_comb begin
    shadow_d = SH_S0;
    unique case (shadow_q)
      SH_S0: begin
        if (a_q && b_q)  shadow_d = SH_S2;
        else if (a_q)    shadow_d = SH_S1;
        else             shadow_d = SH_S0;
      end
      SH_S1:   shadow_d = a_q ? SH_S0 : SH_S1;
      SH_S2:   shadow_d = SH_S0;
      default: shadow_d = SH_S0;
    endcase
    y0_d = (shadow_d == SH_S0) & a_d & b_d;
    y1_d = (shadow_d == SH_S0) | (shadow_d == SH_S1);
  end

  assign cmd_ready    = ready_q;
  assign a            = a_q;
  assign b            = b_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign shadow_state = shadow_q;
  assign exp_y0       = y0_q;
  assign exp_y1       = y1_q;

endmodule

// File: tb/tb_mul_seg_drv.sv
// Self-checking bench for mul_seg_drv: per-cycle vector table plus
// hand-written back-to-back and mid-command reset sequences.
// Define MUL_SEG_DRV_ABORT_EN for both files to exercise the abort path.
module tb_mul_seg_drv;

  localparam int unsigned LEN_W = 8;
  localparam int D_IDLE = 0, D_PULSE = 1, D_REC = 2, D_ENT = 3, D_WAIT = 4, D_EXIT = 5;

  typedef struct {
    logic       vld;
    logic       typ;
    logic [7:0] len;
    logic       ab;
    int         ds;
    int         sh;
  } row_t;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_type;
  logic [LEN_W-1:0] cmd_len;
  logic             a, b, busy, done;
  logic [1:0]       shadow_state;
  logic             exp_y0, exp_y1;
`ifdef MUL_SEG_DRV_ABORT_EN
  logic             abort_r;
`endif

  int   checks;
  int   errors;
  row_t rows [0:31];

  mul_seg_drv #(.LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_type     (cmd_type),
    .cmd_len      (cmd_len),
`ifdef MUL_SEG_DRV_ABORT_EN
    .abort        (abort_r),
`endif
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .shadow_state (shadow_state),
    .exp_y0       (exp_y0),
    .exp_y1       (exp_y1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected outputs for a driver state and receiver shadow state
  task automatic check_state(input string tag, input int ds, input int sh);
    int ea, eb, ebusy, edone, erdy, ey0, ey1;
    ea    = (ds == D_PULSE || ds == D_ENT || ds == D_EXIT) ? 1 : 0;
    eb    = (ds == D_PULSE) ? 1 : 0;
    ebusy = (ds != D_IDLE) ? 1 : 0;
    edone = (ds == D_REC || ds == D_EXIT) ? 1 : 0;
    erdy  = (ds == D_IDLE) ? 1 : 0;
    ey0   = (sh == 0 && ea == 1 && eb == 1) ? 1 : 0;
    ey1   = (sh < 2) ? 1 : 0;
    chk({tag, ".a"},      int'(a),            ea);
    chk({tag, ".b"},      int'(b),            eb);
    chk({tag, ".busy"},   int'(busy),         ebusy);
    chk({tag, ".done"},   int'(done),         edone);
    chk({tag, ".ready"},  int'(cmd_ready),    erdy);
    chk({tag, ".shadow"}, int'(shadow_state), sh);
    chk({tag, ".y0"},     int'(exp_y0),       ey0);
    chk({tag, ".y1"},     int'(exp_y1),       ey1);
  endtask

  // Each row: check outputs of this cycle at negedge, then drive inputs for the next edge
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      check_state($sformatf("row%0d", i), rows[i].ds, rows[i].sh);
      cmd_valid = rows[i].vld;
      cmd_type  = rows[i].typ;
      cmd_len   = rows[i].len;
`ifdef MUL_SEG_DRV_ABORT_EN
      abort_r   = rows[i].ab;
`endif
      @(negedge clk);
    end
  endtask

  function automatic row_t mk(input logic vld, input logic typ, input int len,
                              input logic ab, input int ds, input int sh);
    row_t r;
    r.vld = vld;
    r.typ = typ;
    r.len = 8'(len);
    r.ab  = ab;
    r.ds  = ds;
    r.sh  = sh;
    return r;
  endfunction

  initial begin
    int c, acc, wait_n, dn;
    checks = 0;
    errors = 0;

    // PULSE
    rows[0]  = mk(1, 0, 0, 0, D_IDLE,  0);
    rows[1]  = mk(0, 0, 0, 0, D_PULSE, 0);
    rows[2]  = mk(0, 0, 0, 0, D_REC,   2);
    // HOLD len=4
    rows[3]  = mk(1, 1, 4, 0, D_IDLE,  0);
    rows[4]  = mk(0, 0, 0, 0, D_ENT,   0);
    rows[5]  = mk(0, 0, 0, 0, D_WAIT,  1);
    rows[6]  = mk(0, 0, 0, 0, D_WAIT,  1);
    rows[7]  = mk(0, 0, 0, 0, D_WAIT,  1);
    rows[8]  = mk(0, 0, 0, 0, D_WAIT,  1);
    rows[9]  = mk(0, 0, 0, 0, D_EXIT,  1);
    // HOLD len=0
    rows[10] = mk(1, 1, 0, 0, D_IDLE,  0);
    rows[11] = mk(0, 0, 0, 0, D_ENT,   0);
    rows[12] = mk(0, 0, 0, 0, D_EXIT,  1);
    // PULSE, then HOLD(2) held off while busy, then len changed after capture
    rows[13] = mk(1, 0, 0, 0, D_IDLE,  0);
    rows[14] = mk(1, 1, 2, 0, D_PULSE, 0);
    rows[15] = mk(1, 1, 2, 0, D_REC,   2);
    rows[16] = mk(1, 1, 2, 0, D_IDLE,  0);
    rows[17] = mk(0, 1, 7, 0, D_ENT,   0);
    rows[18] = mk(0, 0, 0, 0, D_WAIT,  1);
    rows[19] = mk(0, 0, 0, 0, D_WAIT,  1);
    rows[20] = mk(0, 0, 0, 0, D_EXIT,  1);
    rows[21] = mk(0, 0, 0, 0, D_IDLE,  0);
    // HOLD len=20 with abort in the third H_WAIT cycle
    rows[22] = mk(1, 1, 20, 0, D_IDLE, 0);
    rows[23] = mk(0, 0, 0,  0, D_ENT,  0);
    rows[24] = mk(0, 0, 0,  0, D_WAIT, 1);
    rows[25] = mk(0, 0, 0,  0, D_WAIT, 1);
    rows[26] = mk(0, 0, 0,  1, D_WAIT, 1);
    rows[27] = mk(0, 0, 0,  0, D_EXIT, 1);
    rows[28] = mk(0, 0, 0,  0, D_IDLE, 0);

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_type  = 1'b0;
    cmd_len   = '0;
`ifdef MUL_SEG_DRV_ABORT_EN
    abort_r   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_state("reset", D_IDLE, 0);
    rst = 1'b0;
    run_rows(0, 21);

    // Back-to-back: PULSE then HOLD(255) with cmd_valid held high
    cmd_valid = 1'b1;
    cmd_type  = 1'b0;
    cmd_len   = '0;
    @(posedge clk);
    #1;
    cmd_type = 1'b1;
    cmd_len  = 8'd255;
    c   = 0;
    acc = -1;
    while (acc < 0 && c < 10) begin
      @(negedge clk);
      c++;
      if (cmd_ready) acc = c;
    end
    chk("b2b.accept_cycle", acc, 3);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_n = 0;
    dn     = 0;
    for (int k = 0; k < 400 && dn == 0; k++) begin
      @(negedge clk);
      if (done) dn = 1;
      else if (busy && !a && !b) wait_n++;
    end
    chk("b2b.done_seen", dn, 1);
    chk("b2b.wait_cycles", wait_n, 255);
    chk("b2b.exit_a", int'(a), 1);
    @(negedge clk);
    check_state("b2b.idle", D_IDLE, 0);

    // Reset in the middle of H_WAIT of HOLD(10)
    cmd_valid = 1'b1;
    cmd_type  = 1'b1;
    cmd_len   = 8'd10;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_state("rstmid.wait", D_WAIT, 1);
    #2;
    rst = 1'b1;
    #1;
    check_state("rstmid.async", D_IDLE, 0);
    @(negedge clk);
    rst = 1'b0;
    run_rows(0, 3);

`ifdef MUL_SEG_DRV_ABORT_EN
    run_rows(22, 28);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
